// File: rtl/stack_ram_responder_if.sv
// Stack RAM responder bus: write port from the stack controller plus pop read request/response.
// master = controller/consumer side, slave = responder.
interface stack_ram_responder_if #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = 8
);
    logic                 ram_write_req;
    logic [DEPTH_LOG-1:0] ram_addr;
    logic [WIDTH-1:0]     ram_write_data;
    logic                 rd_req;
    logic [DEPTH_LOG-1:0] rd_addr;
    logic                 rd_req_ready;
    logic                 rd_valid;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_ready;

    modport master (
        output ram_write_req, ram_addr, ram_write_data, rd_req, rd_addr, rd_ready,
        input  rd_req_ready, rd_valid, rd_data
    );

    modport slave (
        input  ram_write_req, ram_addr, ram_write_data, rd_req, rd_addr, rd_ready,
        output rd_req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/stack_ram_responder.sv
// Stack RAM array with pop-read responder; STACK_RAM_BYPASS_EN selects write-first collision reads.
// Latency: read accepted at edge N is presented after edge N+1 (FIFO empty); writes take effect at the edge.
// Backpressure: writes never stall; at most 2 reads outstanding, rd_req_ready drops when the credit is spent.
module stack_ram_responder #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stack_ram_responder_if.slave   bus
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG];

    logic             rd_take;
    logic             pop;
    logic [1:0]       occ;
    logic [WIDTH-1:0] rd_word;

    logic             s1_vld;
    logic [WIDTH-1:0] s1_dat;

    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;

    // A response leaving this cycle frees a slot for a request arriving this cycle.
    assign pop             = bus.rd_valid & bus.rd_ready;
    assign occ             = {1'b0, s1_vld} + fifo_cnt;
    assign bus.rd_req_ready = (occ < 2'd2) || pop;
    assign rd_take         = bus.rd_req & bus.rd_req_ready;
    assign bus.rd_valid    = (fifo_cnt != 2'd0);
    assign bus.rd_data     = fifo_mem[rd_ptr];

`ifdef STACK_RAM_BYPASS_EN
    assign rd_word = (bus.ram_write_req && (bus.ram_addr == bus.rd_addr)) ?
                     bus.ram_write_data : mem[bus.rd_addr];
`else
    assign rd_word = mem[bus.rd_addr];
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.ram_write_req) begin
            mem[bus.ram_addr] <= bus.ram_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_take;
            if (rd_take) begin
                s1_dat <= rd_word;
            end
        end
    end

    // Credit guarantees the FIFO is never full when stage 1 holds data, so no stall path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (s1_vld) begin
                fifo_mem[wr_ptr] <= s1_dat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, s1_vld} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_stack_ram_responder.sv
// Directed + randomized bench for stack_ram_responder against a queue-based reference model.
module tb_stack_ram_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_ram_responder_if #(.DEPTH_LOG(4), .WIDTH(8)) bus ();

    stack_ram_responder #(.DEPTH_LOG(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding responses in request order, each with the edge after which it is visible.
    logic [7:0] rmem [16];
    logic [7:0] qd [$];
    int         qe [$];
    int         edge_n = 0;

    function automatic bit m_valid();
        return (qd.size() > 0) && (edge_n >= qe[0]);
    endfunction

    function automatic bit m_rdy();
        return (qd.size() < 2) || (m_valid() && bus.rd_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qd.delete();
            qe.delete();
        end else begin
            bit         v;
            bit         r;
            logic [7:0] d;
            v = m_valid();
            r = m_rdy();
            edge_n++;
            if (v && bus.rd_ready) begin
                void'(qd.pop_front());
                void'(qe.pop_front());
            end
            if (bus.rd_req && r) begin
`ifdef STACK_RAM_BYPASS_EN
                d = (bus.ram_write_req && bus.ram_addr == bus.rd_addr) ? bus.ram_write_data : rmem[bus.rd_addr];
`else
                d = rmem[bus.rd_addr];
`endif
                qd.push_back(d);
                qe.push_back(edge_n + 1);
            end
            if (bus.ram_write_req) rmem[bus.ram_addr] = bus.ram_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        check("model_valid", {31'd0, bus.rd_valid}, {31'd0, m_valid()});
        if (m_valid()) check("model_data", {24'd0, bus.rd_data}, {24'd0, qd[0]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic chk_rdy(input string tag);
        #1;
        check(tag, {31'd0, bus.rd_req_ready}, {31'd0, m_rdy()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] coll_exp;
        bus.ram_write_req  = 1'b0;
        bus.ram_addr       = '0;
        bus.ram_write_data = '0;
        bus.rd_req         = 1'b0;
        bus.rd_addr        = '0;
        bus.rd_ready       = 1'b0;

        // Reset state
        #2;
        check("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_data", {24'd0, bus.rd_data}, 32'd0);
        check("rst_req_ready", {31'd0, bus.rd_req_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // Fill addr 0..14 with 0x11..0x1F
        for (int i = 0; i < 15; i++) begin
            bus.ram_write_req  = 1'b1;
            bus.ram_addr       = 4'(i);
            bus.ram_write_data = 8'(8'h11 + i);
            tick();
        end
        bus.ram_write_req = 1'b0;

        // Single read, 1-cycle latency
        bus.rd_req = 1'b1; bus.rd_addr = 4'd14; bus.rd_ready = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check("lat_not_yet", {31'd0, bus.rd_valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, bus.rd_valid}, 32'd1);
        check("lat_data", {24'd0, bus.rd_data}, 32'h1F);
        tick();
        check("lat_drained", {31'd0, bus.rd_valid}, 32'd0);

        // Credit limit: third request refused while consumer stalls
        bus.rd_ready = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
        #1; check("cred_rdy1", {31'd0, bus.rd_req_ready}, 32'd1);
        tick();
        bus.rd_addr = 4'd4;
        #1; check("cred_rdy2", {31'd0, bus.rd_req_ready}, 32'd1);
        tick();
        bus.rd_addr = 4'd5;
        #1; check("cred_rdy3", {31'd0, bus.rd_req_ready}, 32'd0);
        tick();
        bus.rd_req = 1'b0;

        // Hold stability under backpressure
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, bus.rd_valid}, 32'd1);
            check("hold_data", {24'd0, bus.rd_data}, 32'h14);
            check("hold_rdy", {31'd0, bus.rd_req_ready}, 32'd0);
            tick();
        end
        bus.rd_ready = 1'b1;
        #1; check("release_rdy", {31'd0, bus.rd_req_ready}, 32'd1);
        tick();
        check("second_valid", {31'd0, bus.rd_valid}, 32'd1);
        check("second_data", {24'd0, bus.rd_data}, 32'h15);
        tick();
        check("third_dropped", {31'd0, bus.rd_valid}, 32'd0);

        // Read/write collision on addr 7
        bus.ram_write_req = 1'b1; bus.ram_addr = 4'd7; bus.ram_write_data = 8'hAA;
        tick();
        bus.ram_write_data = 8'h55;
        bus.rd_req = 1'b1; bus.rd_addr = 4'd7;
        tick();
        bus.ram_write_req = 1'b0; bus.rd_req = 1'b0;
        tick();
`ifdef STACK_RAM_BYPASS_EN
        coll_exp = 8'h55;
`else
        coll_exp = 8'hAA;
`endif
        check("coll_valid", {31'd0, bus.rd_valid}, 32'd1);
        check("coll_data", {24'd0, bus.rd_data}, {24'd0, coll_exp});
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        check("coll_after", {24'd0, bus.rd_data}, 32'h55);
        tick();

        // Reset with two responses buffered
        bus.rd_ready = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 4'd1;
        tick();
        bus.rd_addr = 4'd2;
        tick();
        bus.rd_req = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, bus.rd_valid}, 32'd1);
        check("pre_rst_rdy", {31'd0, bus.rd_req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("mid_rst_data", {24'd0, bus.rd_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1; check("post_rst_rdy", {31'd0, bus.rd_req_ready}, 32'd1);
        bus.rd_req = 1'b1; bus.rd_addr = 4'd14; bus.rd_ready = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        check("post_rst_data", {24'd0, bus.rd_data}, 32'h1F);
        tick();

        // Streaming: one response per cycle, no credit loss
        for (int i = 0; i < 20; i++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = 4'($urandom_range(0, 14));
            #1; check("stream_rdy", {31'd0, bus.rd_req_ready}, 32'd1);
            if (i >= 2) check("stream_valid", {31'd0, bus.rd_valid}, 32'd1);
            tick();
        end
        bus.rd_req = 1'b0;
        tick();
        tick();

        // Randomized traffic against the model
        bus.ram_write_req = 1'b1; bus.ram_addr = 4'd15; bus.ram_write_data = 8'hE7;
        tick();
        for (int i = 0; i < 400; i++) begin
            bus.ram_write_req  = ($urandom_range(0, 2) == 0);
            bus.ram_addr       = 4'($urandom_range(0, 15));
            bus.ram_write_data = 8'($urandom);
            bus.rd_req         = ($urandom_range(0, 3) != 0);
            bus.rd_addr        = 4'($urandom_range(0, 15));
            bus.rd_ready       = ($urandom_range(0, 2) != 0);
            chk_rdy("rand_rdy");
            tick();
        end
        bus.ram_write_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_ready = 1'b1;
        tick();
        tick();
        tick();
        check("final_empty", {31'd0, bus.rd_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
